c2h_stream_packer: RTL and testbench

- Sits directly downstream of the 128-bit scan-word packer, in the user_clk domain.
- Takes its single-cycle pcie_valid/pcie_data pulses, which carry no backpressure, and buffers them in a show-ahead FIFO.
- Emits them as an AXI4-Stream master to the PCIe C2H channel 0, with tlast packet framing, a flush-on-stop sequence and overflow accounting.

---
 rtl/c2h_stream_packer_if.sv | 35 +++
 rtl/c2h_stream_packer.sv | 212 +++++++++++++++++++++
 tb/tb_c2h_stream_packer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/c2h_stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : c2h_stream_packer_if
// Purpose  : AXI4-Stream bundle between the C2H packer and the PCIe C2H
//            channel 0 sink.
// Signals  : tvalid/tdata/tkeep/tlast driven by the master, tready by the
//            slave.
// Revision : 1.0 - initial release
// ============================================================================
interface c2h_stream_packer_if #(
    parameter int DATA_W = 128
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/c2h_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : c2h_stream_packer
// Purpose  : Buffers single-cycle pcie_valid/pcie_data words (no
//            backpressure) in a show-ahead FIFO and replays them as an
//            AXI4-Stream master with tlast framing every PKT_BEATS beats,
//            a flush/pad sequence on stop, and sticky overflow reporting.
// Ports    : user_clk, user_resetn (async, active-low)
//            c2h_run, pcie_start, pcie_stop   - session control
//            pcie_valid, pcie_data            - input word strobe/data
//            m_axis (master modport)          - output stream
//            fifo_overflow, pkt_cnt, busy     - status
// Revision : 1.0 - initial release
// ============================================================================
module c2h_stream_packer #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_BEATS  = 256
) (
    input  logic                   user_clk,
    input  logic                   user_resetn,
    input  logic                   c2h_run,
    input  logic                   pcie_start,
    input  logic                   pcie_stop,
    input  logic                   pcie_valid,
    input  logic [DATA_W-1:0]      pcie_data,
    c2h_stream_packer_if.master    m_axis,
    output logic                   fifo_overflow,
    output logic [31:0]            pkt_cnt,
    output logic                   busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(PKT_BEATS);

    localparam logic [CW-1:0] c_FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_ONE_CNT   = CW'(1);
    localparam logic [BW-1:0] c_LAST_BEAT = BW'(PKT_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        PAD   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [BW-1:0]       r_beat;
    logic                r_overflow;
    logic [31:0]         r_pkt_cnt;

    logic                w_empty;
    logic                w_full;
    logic                w_tvalid;
    logic                w_tlast;
    logic [DATA_W-1:0]   w_tdata;
    logic                w_hs;
    logic                w_wr;
    logic                w_rd;
    logic                w_drop;
    logic                w_start;

    // Full/empty come from the registered count only, so a same-cycle read
    // never makes room for a write.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);

    always_comb begin
        w_tvalid = 1'b0;
        case (r_state)
            RUN, FLUSH: w_tvalid = !w_empty;
            PAD:        w_tvalid = 1'b1;
            default:    w_tvalid = 1'b0;
        endcase
    end

    // All framing conditions are OR-ed so coincident causes give one tlast.
    assign w_tlast = w_tvalid && ((r_beat == c_LAST_BEAT) ||
                                  (r_state == FLUSH && r_count == c_ONE_CNT) ||
                                  (r_state == PAD));

    assign w_tdata = !w_tvalid        ? '0 :
                     (r_state == PAD) ? '1 : r_mem[r_rd_ptr];

    assign w_hs    = w_tvalid && m_axis.tready;
    assign w_rd    = w_hs && (r_state == RUN || r_state == FLUSH);
    assign w_wr    = pcie_valid && c2h_run && (r_state == RUN) && !w_full;
    assign w_drop  = pcie_valid && c2h_run && (r_state == RUN) && w_full;
    assign w_start = (r_state == IDLE) && pcie_start && c2h_run;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge user_clk or negedge user_resetn) begin
        if (!user_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!c2h_run) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pcie_start) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (pcie_stop) begin
                        w_state_nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    if (w_empty) begin
                        w_state_nxt = (r_beat == '0) ? IDLE : PAD;
                    end else if (r_count == c_ONE_CNT && w_hs) begin
                        // The last entry carries tlast, so the beat counter
                        // is back at zero and no pad beat is needed.
                        w_state_nxt = IDLE;
                    end
                end
                PAD: begin
                    if (w_hs) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge user_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= pcie_data;
        end
    end

    always_ff @(posedge user_clk or negedge user_resetn) begin
        if (!user_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (!c2h_run) begin
            // Abort: buffered words are discarded without handshakes.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat counter, packet counter, overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge user_clk or negedge user_resetn) begin
        if (!user_resetn) begin
            r_beat     <= '0;
            r_pkt_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_beat     <= '0;
            r_pkt_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_hs) begin
                r_beat <= w_tlast ? '0 : r_beat + 1'b1;
            end
            if (w_hs && w_tlast) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tdata  = w_tdata;
    assign m_axis.tlast  = w_tlast;
    assign m_axis.tkeep  = '1;
    assign fifo_overflow = r_overflow;
    assign pkt_cnt       = r_pkt_cnt;
    assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_c2h_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_c2h_stream_packer
// Purpose  : Directed self-checking bench for c2h_stream_packer built with
//            FIFO_DEPTH=16 and PKT_BEATS=4.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_c2h_stream_packer;

    localparam int DATA_W = 128;

    logic              user_clk;
    logic              user_resetn;
    logic              c2h_run;
    logic              pcie_start;
    logic              pcie_stop;
    logic              pcie_valid;
    logic [DATA_W-1:0] pcie_data;
    logic              fifo_overflow;
    logic [31:0]       pkt_cnt;
    logic              busy;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] ones;

    c2h_stream_packer_if #(.DATA_W(DATA_W)) axis ();

    c2h_stream_packer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (16),
        .PKT_BEATS  (4)
    ) dut (
        .user_clk      (user_clk),
        .user_resetn   (user_resetn),
        .c2h_run       (c2h_run),
        .pcie_start    (pcie_start),
        .pcie_stop     (pcie_stop),
        .pcie_valid    (pcie_valid),
        .pcie_data     (pcie_data),
        .m_axis        (axis.master),
        .fifo_overflow (fifo_overflow),
        .pkt_cnt       (pkt_cnt),
        .busy          (busy)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, DATA_W'(axis.tvalid), '0);
        chk({tag, "_tlast"},  DATA_W'(axis.tlast),  '0);
        chk({tag, "_tdata"},  axis.tdata,           '0);
        chk({tag, "_tkeep"},  DATA_W'(axis.tkeep),  DATA_W'(16'hFFFF));
        chk({tag, "_ovf"},    DATA_W'(fifo_overflow), '0);
        chk({tag, "_pkt"},    DATA_W'(pkt_cnt),     '0);
        chk({tag, "_busy"},   DATA_W'(busy),        '0);
    endtask

    task automatic start_session();
        pcie_start = 1'b1;
        tick();
        pcie_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        ones        = '1;
        user_resetn = 1'b0;
        c2h_run     = 1'b0;
        pcie_start  = 1'b0;
        pcie_stop   = 1'b0;
        pcie_valid  = 1'b0;
        pcie_data   = '0;
        axis.tready = 1'b0;
        tick();
        tick();
        chk_reset_outputs("rst");
        user_resetn = 1'b1;
        tick();

        // ---- 1: four words, one packet ---------------------------------
        c2h_run     = 1'b1;
        axis.tready = 1'b1;
        start_session();
        chk("t1_busy", DATA_W'(busy), DATA_W'(1));
        chk("t1_idle_tvalid", DATA_W'(axis.tvalid), '0);
        for (int i = 1; i <= 4; i++) begin
            pcie_valid = 1'b1;
            pcie_data  = DATA_W'(i);
            tick();
            chk($sformatf("t1_tvalid%0d", i), DATA_W'(axis.tvalid), DATA_W'(1));
            chk($sformatf("t1_tdata%0d", i),  axis.tdata, DATA_W'(i));
            chk($sformatf("t1_tlast%0d", i),  DATA_W'(axis.tlast), DATA_W'(i == 4));
        end
        pcie_valid = 1'b0;
        tick();
        chk("t1_drained", DATA_W'(axis.tvalid), '0);
        chk("t1_pkt", DATA_W'(pkt_cnt), DATA_W'(1));

        // ---- 2: overflow with tready low, then drain ---------------------
        axis.tready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            pcie_valid = 1'b1;
            pcie_data  = DATA_W'(i);
            tick();
            if (i == 16) chk("t2_ovf_at16", DATA_W'(fifo_overflow), '0);
        end
        pcie_valid = 1'b0;
        chk("t2_ovf_at17", DATA_W'(fifo_overflow), DATA_W'(1));
        axis.tready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("t2_tvalid%0d", k), DATA_W'(axis.tvalid), DATA_W'(1));
            chk($sformatf("t2_tdata%0d", k),  axis.tdata, DATA_W'(k));
            chk($sformatf("t2_tlast%0d", k),  DATA_W'(axis.tlast), DATA_W'(k % 4 == 0));
            tick();
        end
        chk("t2_empty", DATA_W'(axis.tvalid), '0);
        chk("t2_pkt", DATA_W'(pkt_cnt), DATA_W'(5));
        chk("t2_ovf_sticky", DATA_W'(fifo_overflow), DATA_W'(1));

        // stop with empty FIFO and beat counter 0 -> straight back to IDLE
        pcie_stop = 1'b1;
        tick();
        pcie_stop = 1'b0;
        tick();
        chk("t2_stop_idle", DATA_W'(busy), '0);

        // ---- 3: six words, stop with the sixth ---------------------------
        start_session();
        chk("t3_ovf_clr", DATA_W'(fifo_overflow), '0);
        chk("t3_pkt_clr", DATA_W'(pkt_cnt), '0);
        for (int i = 1; i <= 6; i++) begin
            pcie_valid = 1'b1;
            pcie_data  = DATA_W'(32'h30 + i);
            pcie_stop  = (i == 6);
            tick();
            chk($sformatf("t3_tdata%0d", i), axis.tdata, DATA_W'(32'h30 + i));
            chk($sformatf("t3_tlast%0d", i), DATA_W'(axis.tlast),
                DATA_W'(i == 4 || i == 6));
        end
        pcie_valid = 1'b0;
        pcie_stop  = 1'b0;
        tick();
        chk("t3_busy", DATA_W'(busy), '0);
        chk("t3_tvalid", DATA_W'(axis.tvalid), '0);
        chk("t3_pkt", DATA_W'(pkt_cnt), DATA_W'(2));

        // ---- 4: two words drained, stop -> pad beat ----------------------
        start_session();
        for (int i = 1; i <= 2; i++) begin
            pcie_valid = 1'b1;
            pcie_data  = DATA_W'(32'h40 + i);
            tick();
            chk($sformatf("t4_tdata%0d", i), axis.tdata, DATA_W'(32'h40 + i));
        end
        pcie_valid = 1'b0;
        tick();
        chk("t4_drained", DATA_W'(axis.tvalid), '0);
        pcie_stop = 1'b1;
        tick();
        pcie_stop = 1'b0;
        chk("t4_flush_busy", DATA_W'(busy), DATA_W'(1));
        chk("t4_flush_tvalid", DATA_W'(axis.tvalid), '0);
        tick();
        chk("t4_pad_tvalid", DATA_W'(axis.tvalid), DATA_W'(1));
        chk("t4_pad_tdata", axis.tdata, ones);
        chk("t4_pad_tlast", DATA_W'(axis.tlast), DATA_W'(1));
        tick();
        chk("t4_idle", DATA_W'(busy), '0);
        chk("t4_pkt", DATA_W'(pkt_cnt), DATA_W'(1));
        chk("t4_tvalid", DATA_W'(axis.tvalid), '0);

        // ---- 5: abort with buffered words --------------------------------
        start_session();
        axis.tready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            pcie_valid = 1'b1;
            pcie_data  = DATA_W'(32'h50 + i);
            tick();
        end
        pcie_valid = 1'b0;
        chk("t5_head", axis.tdata, DATA_W'(32'h51));
        c2h_run = 1'b0;
        tick();
        chk("t5_abort_tvalid", DATA_W'(axis.tvalid), '0);
        chk("t5_abort_busy", DATA_W'(busy), '0);
        c2h_run = 1'b1;
        start_session();
        chk("t5_restart_empty", DATA_W'(axis.tvalid), '0);
        pcie_valid = 1'b1;
        pcie_data  = DATA_W'(32'h61);
        tick();
        pcie_valid = 1'b0;
        chk("t5_fresh_data", axis.tdata, DATA_W'(32'h61));
        axis.tready = 1'b1;
        tick();
        chk("t5_fresh_only", DATA_W'(axis.tvalid), '0);

        // ---- 6: async reset mid-packet -----------------------------------
        axis.tready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            pcie_valid = 1'b1;
            pcie_data  = DATA_W'(32'h70 + i);
            tick();
        end
        pcie_valid = 1'b0;
        chk("t6_pre_tvalid", DATA_W'(axis.tvalid), DATA_W'(1));
        #2;
        user_resetn = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        tick();
        user_resetn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            pcie_valid = 1'b1;
            pcie_data  = DATA_W'(32'h80 + i);
            tick();
        end
        pcie_valid = 1'b0;
        chk("t6_ignored_tvalid", DATA_W'(axis.tvalid), '0);
        chk("t6_ignored_busy", DATA_W'(busy), '0);
        start_session();
        chk("t6_new_empty", DATA_W'(axis.tvalid), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
